rf_wb_arbiter: RTL

Owns the single write port of the 16x16 register file and shares it between two writeback requesters: A (ALU) and B (load/store unit). Uses round-robin valid/ready arbitration and drives a registered write stage onto the port.
Also keeps a per-register outstanding-write scoreboard. It raises a stall for reads of registers whose producer has issued but not yet written back.
Sits between the execute/memory stages and the register file, next to decode.

---
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a
// per-register outstanding-write scoreboard that drives decode stalls.
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_dst,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_W-1:0]  b_dst,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_dst,
  output logic              iss_block,
  input  logic [REG_W-1:0]  chk_reg1,
  input  logic [REG_W-1:0]  chk_reg2,
  output logic              stall,
  output logic [REG_W-1:0]  DstReg,
  output logic              WriteReg,
  output logic [DATA_W-1:0] DstData
);

  localparam int NREG = 2 ** REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // last_a is set when A won the most recent transfer; cleared so A wins the first tie
  logic              last_a;
  logic [CNT_W-1:0]  cnt [NREG];

  logic              xfer_a;
  logic              xfer_b;
  logic              xfer;
  logic [REG_W-1:0]  xfer_dst;
  logic [DATA_W-1:0] xfer_data;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic              haz1;
  logic              haz2;

  always_comb begin
    a_ready = !rst && a_valid && (!b_valid || !last_a);
    b_ready = !rst && b_valid && (!a_valid || last_a);
    xfer_a  = a_valid && a_ready;
    xfer_b  = b_valid && b_ready;
    xfer    = xfer_a || xfer_b;
    xfer_dst  = xfer_a ? a_dst  : b_dst;
    xfer_data = xfer_a ? a_data : b_data;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_valid && iss_dst != REG_ZERO && cnt[iss_dst] != CNT_MAX)
      inc_vec[iss_dst] = 1'b1;
    if (WriteReg && cnt[DstReg] != '0)
      dec_vec[DstReg] = 1'b1;
  end

  always_comb begin
    iss_block = !rst && iss_valid && iss_dst != REG_ZERO && cnt[iss_dst] == CNT_MAX;
    // A single pending write that lands this cycle is covered by the RF bypass
    haz1 = chk_reg1 != REG_ZERO &&
           (cnt[chk_reg1] > CNT_ONE ||
            (cnt[chk_reg1] == CNT_ONE && !(WriteReg && DstReg == chk_reg1)));
    haz2 = chk_reg2 != REG_ZERO &&
           (cnt[chk_reg2] > CNT_ONE ||
            (cnt[chk_reg2] == CNT_ONE && !(WriteReg && DstReg == chk_reg2)));
    stall = !rst && (haz1 || haz2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WriteReg <= 1'b0;
      DstReg   <= '0;
      DstData  <= '0;
      last_a   <= 1'b0;
    end else if (xfer) begin
      WriteReg <= xfer_dst != REG_ZERO;
      DstReg   <= xfer_dst;
      DstData  <= xfer_data;
      last_a   <= xfer_a;
    end else begin
      WriteReg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst)
        cnt[r] <= '0;
      else if (inc_vec[r] && !dec_vec[r])
        cnt[r] <= cnt[r] + CNT_ONE;
      else if (dec_vec[r] && !inc_vec[r])
        cnt[r] <= cnt[r] - CNT_ONE;
    end
  end

endmodule
